// File: rtl/obj_box_pkg.sv
// Shared types, constants, colour table and box hit-test helpers for obj_box_overlay.
// on_cross() exists only when OBJ_BOX_CENTER_EN is defined.
package obj_box_pkg;

  localparam int COORD_W   = 11;
  localparam int CNT_W     = 20;
  localparam int CROSS_LEN = 4;
  localparam int BOX_BITS  = 4 * COORD_W;

  localparam logic [15:0] COL_OBJ0 = 16'hF800;
  localparam logic [15:0] COL_OBJ1 = 16'h07E0;
  localparam logic [15:0] COL_OBJ2 = 16'h001F;
  localparam logic [15:0] COL_OBJ3 = 16'hFFE0;

  typedef logic [COORD_W-1:0] coord_t;
  // One extra bit so edge +/- thickness sums never wrap.
  typedef logic [COORD_W:0]   coord_ext_t;

  typedef struct packed {
    coord_t up;
    coord_t down;
    coord_t left;
    coord_t right;
  } box_t;

  function automatic logic [15:0] obj_colour(input logic [1:0] k);
    logic [15:0] c;
    case (k)
      2'd0:    c = COL_OBJ0;
      2'd1:    c = COL_OBJ1;
      2'd2:    c = COL_OBJ2;
      default: c = COL_OBJ3;
    endcase
    return c;
  endfunction

  function automatic logic in_box(input box_t b, input coord_t x, input coord_t y);
    return (x >= b.left) && (x <= b.right) && (y >= b.up) && (y <= b.down);
  endfunction

  function automatic logic on_border(input box_t b, input coord_t x, input coord_t y,
                                     input coord_ext_t bw);
    coord_ext_t xe, ye, l, r, u, d;
    xe = {1'b0, x};
    ye = {1'b0, y};
    l  = {1'b0, b.left};
    r  = {1'b0, b.right};
    u  = {1'b0, b.up};
    d  = {1'b0, b.down};
    return in_box(b, x, y) &&
           ((xe < l + bw) || (xe + bw > r) || (ye < u + bw) || (ye + bw > d));
  endfunction

`ifdef OBJ_BOX_CENTER_EN
  function automatic logic near(input coord_ext_t a, input coord_ext_t c);
    coord_ext_t cl;
    cl = coord_ext_t'(CROSS_LEN);
    return (a + cl >= c) && (a <= c + cl);
  endfunction

  function automatic logic on_cross(input box_t b, input coord_t x, input coord_t y);
    coord_ext_t xe, ye, cx, cy;
    xe = {1'b0, x};
    ye = {1'b0, y};
    cx = ({1'b0, b.left} + {1'b0, b.right}) >> 1;
    cy = ({1'b0, b.up} + {1'b0, b.down}) >> 1;
    return in_box(b, x, y) &&
           (((ye == cy) && near(xe, cx)) || ((xe == cx) && near(ye, cy)));
  endfunction
`endif

endpackage

// File: rtl/obj_box_tracker.sv
// Per-object mask bounding-box accumulator; latches the box at each frame start.
// Box/valid update one cycle after the vsync rising edge; no backpressure (streaming).
module obj_box_tracker
  import obj_box_pkg::*;
#(
  parameter int MIN_PIX = 64
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   vs_rise,
  input  logic   de,
  input  logic   mask,
  input  coord_t x,
  input  coord_t y,
  output box_t   box,
  output logic   valid
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);

  coord_t             min_x, max_x, min_y, max_y;
  logic [CNT_W-1:0]   cnt;

  // Frame start wins over accumulation so a pixel coincident with it is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_x <= '1;
      max_x <= '0;
      min_y <= '1;
      max_y <= '0;
      cnt   <= '0;
      box   <= '0;
      valid <= 1'b0;
    end else if (vs_rise) begin
      if (cnt >= MIN_CNT) begin
        box   <= '{up: min_y, down: max_y, left: min_x, right: max_x};
        valid <= 1'b1;
      end else begin
        valid <= 1'b0;
      end
      min_x <= '1;
      max_x <= '0;
      min_y <= '1;
      max_y <= '0;
      cnt   <= '0;
    end else if (de && mask) begin
      if (x < min_x) min_x <= x;
      if (x > max_x) max_x <= x;
      if (y < min_y) min_y <= y;
      if (y > max_y) max_y <= y;
      if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/obj_box_overlay.sv
// Draws per-object bounding boxes (centre cross too with OBJ_BOX_CENTER_EN) onto RGB565 video.
// Latency 1 cycle pre_* to post_*; boxes lag one frame; no backpressure (streaming).
module obj_box_overlay
  import obj_box_pkg::*;
#(
  parameter int IMG_HDISP = 960,
  parameter int IMG_VDISP = 540,
  parameter int NUM_OBJ   = 2,
  parameter int BOX_W     = 2,
  parameter int MIN_PIX   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pre_frame_vsync,
  input  logic                        pre_frame_href,
  input  logic                        pre_frame_de,
  input  logic [15:0]                 pre_rgb,
  input  logic [NUM_OBJ-1:0]          pre_mask,
  output logic                        post_frame_vsync,
  output logic                        post_frame_href,
  output logic                        post_frame_de,
  output logic [15:0]                 post_rgb,
  output logic [NUM_OBJ-1:0]          box_valid,
  output logic [BOX_BITS*NUM_OBJ-1:0] box_coord
);

  localparam coord_t     X_MAX = coord_t'(IMG_HDISP - 1);
  localparam coord_t     Y_MAX = coord_t'(IMG_VDISP - 1);
  localparam coord_ext_t BW    = coord_ext_t'(BOX_W);

  logic         vs_d, de_d;
  logic         vs_rise, de_fall;
  coord_t       x_cnt, y_cnt;
  box_t         boxes [NUM_OBJ];
  logic [NUM_OBJ-1:0] draw;
  logic [15:0]  pix_out;

  assign vs_rise = pre_frame_vsync & ~vs_d;
  assign de_fall = de_d & ~pre_frame_de;

  // x/y hold the coordinate of the pixel currently on pre_*; both saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d  <= 1'b0;
      de_d  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      vs_d <= pre_frame_vsync;
      de_d <= pre_frame_de;
      if (pre_frame_de) begin
        if (x_cnt != X_MAX) x_cnt <= x_cnt + 1'b1;
      end else if (de_fall) begin
        x_cnt <= '0;
      end
      if (vs_rise) begin
        y_cnt <= '0;
      end else if (de_fall && (y_cnt != Y_MAX)) begin
        y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_OBJ; k++) begin : g_obj
    obj_box_tracker #(
      .MIN_PIX (MIN_PIX)
    ) u_trk (
      .clk     (clk),
      .rst     (rst),
      .vs_rise (vs_rise),
      .de      (pre_frame_de),
      .mask    (pre_mask[k]),
      .x       (x_cnt),
      .y       (y_cnt),
      .box     (boxes[k]),
      .valid   (box_valid[k])
    );

    assign box_coord[k*BOX_BITS +: BOX_BITS] = boxes[k];

`ifdef OBJ_BOX_CENTER_EN
    assign draw[k] = box_valid[k] &&
                     (on_border(boxes[k], x_cnt, y_cnt, BW) || on_cross(boxes[k], x_cnt, y_cnt));
`else
    assign draw[k] = box_valid[k] && on_border(boxes[k], x_cnt, y_cnt, BW);
`endif
  end

  // Walk from the highest index down so the lowest-index object wins overlaps.
  always_comb begin
    pix_out = pre_rgb;
    for (int k = NUM_OBJ - 1; k >= 0; k--) begin
      if (draw[k]) pix_out = obj_colour(k[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_de    <= 1'b0;
      post_rgb         <= '0;
    end else begin
      post_frame_vsync <= pre_frame_vsync;
      post_frame_href  <= pre_frame_href;
      post_frame_de    <= pre_frame_de;
      post_rgb         <= pre_frame_de ? pix_out : 16'h0000;
    end
  end

endmodule

// File: tb/tb_obj_box_overlay.sv
// Directed bench for obj_box_overlay: default instance plus a MIN_PIX=1 instance for the corner pixel.
// Expected values are hand-derived; OBJ_BOX_CENTER_EN selects the expected centre-cross pixel.
module tb_obj_box_overlay;

  logic        clk;
  logic        rst;
  logic        vsync, href, de;
  logic [15:0] rgb;
  logic [1:0]  mask;

  logic        d0_vsync, d0_href, d0_de;
  logic [15:0] d0_rgb;
  logic [1:0]  d0_valid;
  logic [87:0] d0_coord;
  logic        d1_vsync, d1_href, d1_de;
  logic [15:0] d1_rgb;
  logic [1:0]  d1_valid;
  logic [87:0] d1_coord;

  int checks = 0;
  int errors = 0;
  int mod_cnt;
  int grn_cnt;
  logic [15:0] line0 [0:1199];
  logic [15:0] line1 [0:1199];

  obj_box_overlay dut (
    .clk(clk), .rst(rst),
    .pre_frame_vsync(vsync), .pre_frame_href(href), .pre_frame_de(de),
    .pre_rgb(rgb), .pre_mask(mask),
    .post_frame_vsync(d0_vsync), .post_frame_href(d0_href), .post_frame_de(d0_de),
    .post_rgb(d0_rgb), .box_valid(d0_valid), .box_coord(d0_coord)
  );

  obj_box_overlay #(.MIN_PIX(1)) dut1 (
    .clk(clk), .rst(rst),
    .pre_frame_vsync(vsync), .pre_frame_href(href), .pre_frame_de(de),
    .pre_rgb(rgb), .pre_mask(mask),
    .post_frame_vsync(d1_vsync), .post_frame_href(d1_href), .post_frame_de(d1_de),
    .post_rgb(d1_rgb), .box_valid(d1_valid), .box_coord(d1_coord)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input int i);
    return 16'h1000 + 16'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input int i);
    line0[i] = d0_rgb;
    line1[i] = d1_rgb;
    if (d0_rgb !== pix(i)) mod_cnt++;
    if (d0_rgb === 16'h07E0) grn_cnt++;
  endtask

  // One line of len pixels; mask ranges are pixel indices within the line.
  task automatic drive_line(input int len, input int m0lo, input int m0hi,
                            input int m1lo, input int m1hi);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i > 0) cap(i - 1);
      de   = 1'b1;
      href = 1'b1;
      rgb  = pix(i);
      mask = {(i >= m1lo) && (i <= m1hi), (i >= m0lo) && (i <= m0hi)};
    end
    @(negedge clk);
    cap(len - 1);
    de   = 1'b0;
    href = 1'b0;
    rgb  = 16'h0000;
    mask = 2'b00;
    @(negedge clk);
  endtask

  task automatic short_lines(input int n);
    for (int l = 0; l < n; l++) drive_line(1, -1, -1, -1, -1);
  endtask

  task automatic frame_start();
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; de = 1'b0; rgb = 16'h0; mask = 2'b00;
    mod_cnt = 0; grn_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_vsync", d0_vsync, 0);
    check("rst_de", d0_de, 0);
    check("rst_rgb", d0_rgb, 0);
    check("rst_valid", d0_valid, 0);
    check("rst_coord", d0_coord[63:0], 0);
    rst = 1'b0;

    // Frame 1: obj0 block x 200..299, y 100..149; obj1 only 10 pixels.
    frame_start();
    short_lines(100);
    drive_line(300, 200, 299, 0, 9);
    for (int l = 101; l < 150; l++) drive_line(300, 200, 299, -1, -1);

    // Frame 2: overlay of frame-1 boxes, then reset at line 270.
    frame_start();
    grn_cnt = 0;
    check("f2_valid0", d0_valid[0], 1);
    check("f2_valid1", d0_valid[1], 0);
    check("f2_coord0", d0_coord[43:0], {11'd100, 11'd149, 11'd200, 11'd299});
    short_lines(100);
    drive_line(300, -1, -1, -1, -1);
    check("f2_top_249_100", line0[249], 16'hF800);
    check("f2_out_199_100", line0[199], pix(199));
    short_lines(19);
    drive_line(300, -1, -1, -1, -1);
    check("f2_left_200_120", line0[200], 16'hF800);
    check("f2_left_201_120", line0[201], 16'hF800);
    check("f2_in_202_120", line0[202], pix(202));
    check("f2_in_250_120", line0[250], pix(250));
    check("f2_in_297_120", line0[297], pix(297));
    check("f2_right_299_120", line0[299], 16'hF800);
    short_lines(3);
    drive_line(300, -1, -1, -1, -1);
`ifdef OBJ_BOX_CENTER_EN
    check("f2_centre_249_124", line0[249], 16'hF800);
`else
    check("f2_centre_249_124", line0[249], pix(249));
`endif
    check("f2_in_244_124", line0[244], pix(244));
    check("f2_no_obj1_colour", grn_cnt, 0);
    short_lines(145);
    @(negedge clk);
    de = 1'b1; href = 1'b1; rgb = pix(0); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_rgb", d0_rgb, 0);
    check("rst_mid_de", d0_de, 0);
    check("rst_mid_valid", d0_valid, 0);
    de = 1'b0; href = 1'b0; rgb = 16'h0;
    drive_line(50, -1, -1, -1, -1);
    short_lines(5);

    // Frame 3: must be untouched; accumulate overlapping boxes sharing x=300.
    frame_start();
    mod_cnt = 0;
    check("f3_valid", d0_valid, 0);
    short_lines(100);
    for (int l = 100; l < 150; l++) drive_line(351, 200, 300, 300, 349);
    check("f3_unmodified", mod_cnt, 0);

    // Frame 4: boxes restored; obj0 wins on the shared edge.
    frame_start();
    check("f4_valid", d0_valid, 2'b11);
    check("f4_coord0", d0_coord[43:0], {11'd100, 11'd149, 11'd200, 11'd300});
    check("f4_coord1", d0_coord[87:44], {11'd100, 11'd149, 11'd300, 11'd349});
    short_lines(120);
    drive_line(351, -1, -1, -1, -1);
    check("f4_left_200_120", line0[200], 16'hF800);
    check("f4_shared_300_120", line0[300], 16'hF800);
    check("f4_obj1_301_120", line0[301], 16'h07E0);
    check("f4_obj1_349_120", line0[349], 16'h07E0);
    check("f4_in_260_120", line0[260], pix(260));

    // Frame 5: single mask pixel at (959,539) on a 1200-pixel line.
    frame_start();
    short_lines(539);
    drive_line(1200, 959, 959, -1, -1);

    // Frame 6: single-pixel box drawn; saturated x keeps hitting column 959.
    frame_start();
    check("f6_d1_valid0", d1_valid[0], 1);
    check("f6_d1_coord0", d1_coord[43:0], {11'd539, 11'd539, 11'd959, 11'd959});
    check("f6_d0_valid0", d0_valid[0], 0);
    short_lines(539);
    drive_line(1200, -1, -1, -1, -1);
    check("f6_d1_958_539", line1[958], pix(958));
    check("f6_d1_959_539", line1[959], 16'hF800);
    check("f6_d1_1199_539", line1[1199], 16'hF800);
    check("f6_d0_1199_539", line0[1199], pix(1199));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
